vram_tile_writer: RTL and testbench

//  Write side of the tile-map video RAM scanned by the VGA path. Accepts draw commands
//  (single tile, filled rectangle, full-screen clear) from game logic, converts tile

---
 rtl/vram_tile_writer_pkg.sv | 36 +++
 rtl/vram_tile_writer_if.sv | 31 +++
 rtl/vram_tile_writer_tile_addr_counter.sv | 76 +++++++
 rtl/vram_tile_writer.sv | 123 ++++++++++++
 tb/tb_vram_tile_writer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_tile_writer_pkg.sv
// Shared constants and types for the tile-map VRAM write path.
// The VGA read side uses the same base address and tile geometry.
package vram_tile_writer_pkg;

  localparam logic [15:0] DEF_VGA_BASE_ADDR = 16'hB000;
  localparam int unsigned DEF_TILE_COLS     = 160;
  localparam int unsigned DEF_TILE_ROWS     = 120;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_FILL  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // A command normalised to a rectangle, plus its accept/reject verdict.
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] w;
    logic [6:0] h;
    logic       reject;
  } cmd_dec_t;

  // Exclusive end coordinate clipped to the screen edge; the wide sum never wraps.
  function automatic logic [8:0] clip_end(input logic [8:0] sum, input logic [8:0] limit);
    return (sum > limit) ? limit : sum;
  endfunction

endpackage

// File: rtl/vram_tile_writer_if.sv
// Command and RAM write-port bundle for vram_tile_writer.
// slave is the writer's view, master is the game-logic/RAM-side view.
interface vram_tile_writer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [15:0] cmd_data;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_grant;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_data, wr_grant,
    input  cmd_ready, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_data, wr_grant,
    output cmd_ready, wr_en, wr_addr, wr_data, busy, done, err
  );

endinterface

// File: rtl/vram_tile_writer_tile_addr_counter.sv
// Row-major tile scanner: walks a clipped rectangle and keeps the RAM address
// registered, stepping the row base by the stride instead of multiplying per tile.
module tile_addr_counter
  import vram_tile_writer_pkg::*;
#(
  parameter logic [15:0] VGA_BASE_ADDR = DEF_VGA_BASE_ADDR,
  parameter int unsigned TILE_COLS     = DEF_TILE_COLS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [7:0]  x_start,
  input  logic [6:0]  y_start,
  input  logic [8:0]  x_end,
  input  logic [7:0]  y_end,
  output logic [15:0] wr_addr,
  output logic        last
);

  localparam logic [14:0] STRIDE = 15'(TILE_COLS);

  logic [7:0]  col_q;
  logic [7:0]  x_start_q;
  logic [6:0]  row_q;
  logic [14:0] row_base_q;
  logic [8:0]  x_end_q;
  logic [7:0]  y_end_q;

  logic [8:0]  col_inc;
  logic [7:0]  row_inc;
  logic        row_wrap;
  logic [14:0] row_base_nxt;
  logic [14:0] load_base;

  always_comb begin
    col_inc      = {1'b0, col_q} + 9'd1;
    row_inc      = {1'b0, row_q} + 8'd1;
    row_wrap     = (col_inc == x_end_q);
    last         = row_wrap && (row_inc == y_end_q);
    row_base_nxt = row_base_q + STRIDE;
    // Constant-coefficient product only at command load; the scan itself is add-only.
    load_base    = 15'(y_start) * STRIDE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q      <= '0;
      x_start_q  <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      wr_addr    <= '0;
    end else if (load) begin
      col_q      <= x_start;
      x_start_q  <= x_start;
      row_q      <= y_start;
      row_base_q <= load_base;
      x_end_q    <= x_end;
      y_end_q    <= y_end;
      wr_addr    <= VGA_BASE_ADDR + 16'(load_base) + 16'(x_start);
    end else if (advance) begin
      if (row_wrap) begin
        col_q      <= x_start_q;
        row_q      <= row_q + 7'd1;
        row_base_q <= row_base_nxt;
        wr_addr    <= VGA_BASE_ADDR + 16'(row_base_nxt) + 16'(x_start_q);
      end else begin
        col_q      <= col_q + 8'd1;
        wr_addr    <= wr_addr + 16'd1;
      end
    end
  end

endmodule

// File: rtl/vram_tile_writer.sv
// Write side of the tile-map VRAM: decodes WRITE/FILL/CLEAR commands into
// clipped rectangles and streams one glyph-address write per granted cycle.
module vram_tile_writer
  import vram_tile_writer_pkg::*;
#(
  parameter logic [15:0] VGA_BASE_ADDR = DEF_VGA_BASE_ADDR,
  parameter int unsigned TILE_COLS     = DEF_TILE_COLS,
  parameter int unsigned TILE_ROWS     = DEF_TILE_ROWS
) (
  input logic               clk,
  input logic               reset,
  vram_tile_writer_if.slave bus
);

  localparam logic [8:0] COLS9 = 9'(TILE_COLS);
  localparam logic [7:0] COLS8 = 8'(TILE_COLS);
  localparam logic [8:0] ROWS9 = 9'(TILE_ROWS);
  localparam logic [6:0] ROWS7 = 7'(TILE_ROWS);

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic [15:0] data_q;
  logic        load;
  logic        advance;
  logic        last;
  logic        ready;
  cmd_dec_t    dec;
  logic [8:0]  x_end;
  logic [7:0]  y_end;

  // WRITE and CLEAR are folded into FILL so one scan path serves all three.
  always_comb begin
    dec.x      = bus.cmd_x;
    dec.y      = bus.cmd_y;
    dec.w      = bus.cmd_w;
    dec.h      = bus.cmd_h;
    dec.reject = 1'b0;
    case (cmd_op_e'(bus.cmd_op))
      OP_WRITE: begin
        dec.w = 8'd1;
        dec.h = 7'd1;
      end
      OP_FILL: ;
      OP_CLEAR: begin
        dec.x = '0;
        dec.y = '0;
        dec.w = COLS8;
        dec.h = ROWS7;
      end
      default: dec.reject = 1'b1;
    endcase
    if (({1'b0, dec.x} >= COLS9) || ({2'b0, dec.y} >= ROWS9) ||
        (dec.w == '0) || (dec.h == '0))
      dec.reject = 1'b1;
    x_end = clip_end({1'b0, dec.x} + {1'b0, dec.w}, COLS9);
    y_end = 8'(clip_end({2'b0, dec.y} + {2'b0, dec.h}, ROWS9));
  end

  assign ready = (state_q == ST_IDLE) && !reset;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && ready) begin
          if (dec.reject) begin
            err_d = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.wr_grant) begin
          if (last) state_d = ST_DONE;
          else      advance = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (load) data_q <= bus.cmd_data;
    end
  end

  tile_addr_counter #(
    .VGA_BASE_ADDR(VGA_BASE_ADDR),
    .TILE_COLS    (TILE_COLS)
  ) u_tile_addr_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .advance(advance),
    .x_start(dec.x),
    .y_start(dec.y),
    .x_end  (x_end),
    .y_end  (y_end),
    .wr_addr(bus.wr_addr),
    .last   (last)
  );

  assign bus.cmd_ready = ready;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.wr_en     = (state_q == ST_RUN);
  assign bus.wr_data   = data_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_vram_tile_writer.sv
// Scoreboard bench for vram_tile_writer: a rectangle-level model queues the
// expected writes and done/err events; a monitor retires them as the DUT emits them.
module tb_vram_tile_writer;

  localparam int BASE = 'hB000;
  localparam int COLS = 160;
  localparam int ROWS = 120;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vram_tile_writer_if bus();

  vram_tile_writer #(
    .VGA_BASE_ADDR(16'hB000),
    .TILE_COLS    (160),
    .TILE_ROWS    (120)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  wr_t         wq[$];
  int          eq[$];
  int          total = 0;
  int          bad = 0;
  int          retired = 0;
  bit          capture_first = 0;
  logic [15:0] first_addr = '0;
  logic [15:0] last_addr = '0;
  int          grant_mode = 0;   // 0: always granted, 1: random, 2: manual
  bit          manual_grant = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // RAM arbiter stand-in
  initial begin
    bus.wr_grant = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (grant_mode)
        1:       bus.wr_grant = 1'($urandom_range(0, 1));
        2:       bus.wr_grant = manual_grant;
        default: bus.wr_grant = 1'b1;
      endcase
    end
  end

  // Monitor: retire writes/events against the scoreboard queues.
  initial begin
    bit          stall_prev;
    logic [15:0] prev_addr, prev_data;
    wr_t         e;
    int          k;
    stall_prev = 0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 0;
        continue;
      end
      if (stall_prev) begin
        check("hold_en", bus.wr_en, 1'b1);
        check("hold_addr", bus.wr_addr, prev_addr);
        check("hold_data", bus.wr_data, prev_data);
      end
      if (bus.wr_en && bus.wr_grant) begin
        if (wq.size() == 0) begin
          flag_fail("unexpected_write", bus.wr_addr);
        end else begin
          e = wq.pop_front();
          check("wr_addr", bus.wr_addr, e.addr);
          check("wr_data", bus.wr_data, e.data);
        end
        retired++;
        if (capture_first) begin
          first_addr    = bus.wr_addr;
          capture_first = 0;
        end
        last_addr = bus.wr_addr;
      end
      stall_prev = bus.wr_en && !bus.wr_grant;
      prev_addr  = bus.wr_addr;
      prev_data  = bus.wr_data;
      if (bus.done) begin
        if (eq.size() == 0) flag_fail("unexpected_done", 1);
        else begin
          k = eq.pop_front();
          check("done_event", k, EV_DONE);
          check("writes_left_at_done", wq.size(), 0);
        end
      end
      if (bus.err) begin
        if (eq.size() == 0) flag_fail("unexpected_err", 1);
        else begin
          k = eq.pop_front();
          check("err_event", k, EV_ERR);
        end
      end
    end
  end

  // Model: every command is a clipped rectangle written row by row.
  task automatic model_cmd(input int op, input int x, input int y, input int w, input int h,
                           input logic [15:0] data, output bit rej);
    int xs, ys, ws, hs, xe, ye;
    rej = 0;
    xs = x; ys = y; ws = w; hs = h;
    case (op)
      0: begin ws = 1; hs = 1; end
      1: ;
      2: begin xs = 0; ys = 0; ws = COLS; hs = ROWS; end
      default: rej = 1;
    endcase
    if (xs >= COLS || ys >= ROWS || ws == 0 || hs == 0) rej = 1;
    if (rej) begin
      eq.push_back(EV_ERR);
    end else begin
      xe = (xs + ws > COLS) ? COLS : xs + ws;
      ye = (ys + hs > ROWS) ? ROWS : ys + hs;
      for (int r = ys; r < ye; r++)
        for (int c = xs; c < xe; c++)
          wq.push_back('{addr: 16'(BASE + r * COLS + c), data: data});
      eq.push_back(EV_DONE);
    end
  endtask

  // Returns at the negedge following the accept edge.
  task automatic send(input int op, input int x, input int y, input int w, input int h,
                      input logic [15:0] data);
    bit rej;
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) flag_fail("ready_timeout", n);
    bus.cmd_op    = 2'(op);
    bus.cmd_x     = 8'(x);
    bus.cmd_y     = 7'(y);
    bus.cmd_w     = 8'(w);
    bus.cmd_h     = 7'(h);
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    model_cmd(op, x, y, w, h, data, rej);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("first_wr_latency", bus.wr_en, !rej);
    check("ready_after_accept", bus.cmd_ready, rej);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((wq.size() != 0 || eq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (wq.size() != 0 || eq.size() != 0) begin
      flag_fail("completion_timeout", wq.size());
      wq.delete();
      eq.delete();
    end
    @(negedge clk);
    check("busy_after_cmd", bus.busy, 1'b0);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_w     = '0;
    bus.cmd_h     = '0;
    bus.cmd_data  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {bus.cmd_ready, bus.wr_en, bus.busy, bus.done, bus.err}, 5'b0);
    check("rst_addr", bus.wr_addr, 16'h0);
    check("rst_data", bus.wr_data, 16'h0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_idle", bus.cmd_ready, 1'b1);

    capture_first = 1;
    send(0, 0, 0, 0, 0, 16'h0040);
    wait_done(100);
    check("write_origin", first_addr, 16'hB000);

    send(0, 159, 119, 0, 0, 16'h1234);
    wait_done(100);
    check("write_max_addr", last_addr, 16'hFAFF);

    send(1, 158, 0, 4, 2, 16'h0007);
    wait_done(100);
    send(1, 150, 115, 255, 127, 16'h5555);
    wait_done(500);

    grant_mode   = 2;
    manual_grant = 1;
    send(1, 10, 5, 2, 1, 16'h0ABC);
    manual_grant = 0;
    repeat (3) @(negedge clk);
    manual_grant = 1;
    wait_done(100);
    grant_mode = 0;

    r0 = retired;
    send(0, 160, 0, 0, 0, 16'h1111);
    wait_done(20);
    send(3, 1, 1, 1, 1, 16'h2222);
    wait_done(20);
    send(1, 0, 0, 0, 5, 16'h3333);
    wait_done(20);
    send(1, 0, 0, 5, 0, 16'h4444);
    wait_done(20);
    send(0, 0, 120, 0, 0, 16'h6666);
    wait_done(20);
    check("reject_no_writes", retired - r0, 0);

    r0 = retired;
    capture_first = 1;
    send(2, 7, 7, 7, 7, 16'h0000);
    wait_done(25000);
    check("clear_count", retired - r0, COLS * ROWS);
    check("clear_first", first_addr, 16'hB000);
    check("clear_last", last_addr, 16'hFAFF);

    grant_mode = 1;
    for (int i = 0; i < 40; i++) begin
      int op, x;
      op = $urandom_range(0, 3);
      if (op == 2) op = 1;
      x = ($urandom_range(0, 3) == 0) ? 150 + $urandom_range(0, 12) : $urandom_range(0, 175);
      send(op, x, $urandom_range(0, 127), $urandom_range(0, 20), $urandom_range(0, 8),
           16'($urandom));
      wait_done(2000);
    end
    grant_mode = 0;

    r0 = retired;
    send(2, 0, 0, 0, 0, 16'hBEEF);
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("ready_in_reset", bus.cmd_ready, 1'b0);
    @(negedge clk);
    check("abort_ctrl", {bus.wr_en, bus.busy, bus.done, bus.err}, 4'b0);
    check("abort_addr", bus.wr_addr, 16'h0);
    check("abort_data", bus.wr_data, 16'h0);
    check("abort_partial", retired - r0, 41);
    wq.delete();
    eq.delete();
    reset = 1'b0;
    send(0, 3, 2, 0, 0, 16'h00AA);
    wait_done(100);
    check("post_reset_write", last_addr, 16'hB143);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
